// File: rtl/enc_pkg.sv
// Shared types and constants for the 16-to-4 round-robin encoder.
// Sized to pair with the active-low 4x16 decoder path downstream.
package enc_pkg;
  localparam int N_REQ  = 16;
  localparam int CODE_W = 4;

  typedef logic [N_REQ-1:0]  req_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input req_t r);
    return |(r & (r - req_t'(1)));
  endfunction
endpackage

// File: rtl/enc8x3.sv
// Combinational 8-to-3 priority encoder, lowest index wins, with any-active flag.
// Zero latency; no flow control.
module enc8x3 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end
endmodule

// File: rtl/enc16x4_rr.sv
// Sequential 16-to-4 encoder, round-robin (RR_EN=1) or fixed priority; result one cycle after capture.
// valid/ready output: result held stable until accepted, back-to-back capture on the transfer edge.
module enc16x4_rr
  import enc_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_n,
  input  logic                ready,
  output logic                valid,
  output logic [CODE_W-1:0]   code,
  output logic                multi
);
  state_t state_q, state_d;
  code_t  ptr_q, ptr_d;
  code_t  code_q, code_d;
  logic   multi_q, multi_d;
  logic   valid_q, valid_d;

  req_t   req, mask, masked;
  code_t  ptr_nxt, sel_ptr, win, m_code, u_code;
  logic   xfer, any_req;

  logic [2:0] ml_idx, mh_idx, ul_idx, uh_idx;
  logic       ml_any, mh_any, ul_any, uh_any;

  assign req     = ~req_n;
  assign any_req = |req;
  assign xfer    = (state_q == OFFER) && ready;

  // A capture on the transfer edge must already arbitrate with the advanced pointer.
  assign ptr_nxt = RR_EN ? code_t'(code_q + 4'd1) : '0;
  assign sel_ptr = xfer ? ptr_nxt : ptr_q;
  assign mask    = {N_REQ{1'b1}} << sel_ptr;
  assign masked  = req & mask;

  enc8x3 u_mask_lo (.req(masked[7:0]),  .idx(ml_idx), .any(ml_any));
  enc8x3 u_mask_hi (.req(masked[15:8]), .idx(mh_idx), .any(mh_any));
  enc8x3 u_full_lo (.req(req[7:0]),     .idx(ul_idx), .any(ul_any));
  enc8x3 u_full_hi (.req(req[15:8]),    .idx(uh_idx), .any(uh_any));

  assign m_code = ml_any ? {1'b0, ml_idx} : {1'b1, mh_idx};
  assign u_code = ul_any ? {1'b0, ul_idx} : {1'b1, uh_idx};
  assign win    = (ml_any || mh_any) ? m_code : u_code;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    multi_d = multi_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          code_d  = win;
          multi_d = multi_hot(req);
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ready) begin
          ptr_d = ptr_nxt;
          if (any_req) begin
            code_d  = win;
            multi_d = multi_hot(req);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      code_q  <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign code  = code_q;
  assign multi = multi_q;
endmodule
